// File: rtl/comparator_pkg.sv
// Shared definitions for the registered magnitude comparator.
//
// Contents:
//   SLICE_W      - width of one compare slice (one nibble)
//   rel_e        - 3-bit one-hot relation code (REL_EQ / REL_GT / REL_LT)
//   rel_flags_t  - the eq / gr / less flag triple as driven on the top ports
//   rel_to_flags - maps a relation code onto the flag triple

package comparator_pkg;

    localparam int unsigned SLICE_W = 4;

    // The code is already one-hot so the flag mapping is a pure rewire, but
    // keeping it as an enum gives readable waveforms and a single decode point.
    typedef enum logic [2:0] {
        REL_EQ = 3'b001,
        REL_GT = 3'b010,
        REL_LT = 3'b100
    } rel_e;

    typedef struct packed {
        logic eq;
        logic gr;
        logic less;
    } rel_flags_t;

    function automatic rel_flags_t rel_to_flags(input rel_e rel);
        rel_flags_t flags;
        flags = '0;
        unique case (rel)
            REL_EQ:  flags.eq   = 1'b1;
            REL_GT:  flags.gr   = 1'b1;
            REL_LT:  flags.less = 1'b1;
            default: flags      = '0;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// One nibble of the magnitude compare.
//
// Ports:
//   a, b      - SLICE_W-bit operand slices
//   sign_msb  - treat bit SLICE_W-1 as a two's-complement sign bit
//               (only ever set on the most significant slice in signed mode)
//   slice_eq  - a == b (bitwise, independent of sign_msb)
//   slice_gt  - a > b under the selected interpretation

module comparator_slice
    import comparator_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               sign_msb,
    output logic               slice_eq,
    output logic               slice_gt
);

    logic sign_differs;

    always_comb begin
        slice_eq     = (a == b);
        sign_differs = sign_msb && (a[SLICE_W-1] != b[SLICE_W-1]);
        // With differing sign bits the non-negative operand wins; with equal
        // sign bits an unsigned compare of the whole slice gives the right
        // order for the low bits since the MSBs cancel out.
        if (sign_differs) begin
            slice_gt = b[SLICE_W-1];
        end else begin
            slice_gt = (a > b);
        end
    end

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator.
//
// Splits a and b into WIDTH/4 nibble slices, compares each slice in parallel,
// resolves the relation MSB-slice-first and registers a one-hot eq/gr/less
// flag set one cycle after each accepted sample.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset, clears all outputs
//   in_valid     - qualifies a, b and signed_mode this cycle
//   signed_mode  - 1: two's-complement compare, 0: unsigned compare
//   a, b         - WIDTH-bit operands
//   out_valid    - flags belong to a sample accepted on the last edge
//   eq, gr, less - registered relation of a to b (one-hot once loaded)

module comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             eq,
    output logic             gr,
    output logic             less
);

    localparam int unsigned NUM_SLICES = WIDTH / SLICE_W;

    logic [NUM_SLICES-1:0] slice_eq;
    logic [NUM_SLICES-1:0] slice_gt;

    rel_e       rel_d;
    logic       decided;
    rel_flags_t flags_d, flags_q;
    logic       valid_d, valid_q;

    // ------------------------------------------------------------------
    // Per-nibble compare
    // ------------------------------------------------------------------
    for (genvar i = 0; i < int'(NUM_SLICES); i++) begin : g_slice
        localparam bit IS_TOP = (i == int'(NUM_SLICES) - 1);

        comparator_slice u_slice (
            .a        (a[i*SLICE_W +: SLICE_W]),
            .b        (b[i*SLICE_W +: SLICE_W]),
            .sign_msb (signed_mode && IS_TOP),
            .slice_eq (slice_eq[i]),
            .slice_gt (slice_gt[i])
        );
    end

    // ------------------------------------------------------------------
    // Priority cascade: the highest non-equal slice decides
    // ------------------------------------------------------------------
    always_comb begin
        rel_d   = REL_EQ;
        decided = 1'b0;
        for (int i = int'(NUM_SLICES) - 1; i >= 0; i--) begin
            if (!decided && !slice_eq[i]) begin
                rel_d   = slice_gt[i] ? REL_GT : REL_LT;
                decided = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = in_valid;
        // Idle cycles keep the last flags, so garbage on a/b is never loaded.
        flags_d = in_valid ? rel_to_flags(rel_d) : flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign eq        = flags_q.eq;
    assign gr        = flags_q.gr;
    assign less      = flags_q.less;

endmodule

// File: tb/tb_comparator.sv
// Directed bench for comparator: a 4-bit and an 8-bit instance share clk/rst.
// Table-driven vectors cover the compare function; hand sequences cover
// reset, flag hold on idle cycles and asynchronous reset.

module tb_comparator;

    logic clk;
    logic rst;

    logic       iv4, sm4, ov4, eq4, gr4, lt4;
    logic [3:0] a4, b4;
    logic       iv8, sm8, ov8, eq8, gr8, lt8;
    logic [7:0] a8, b8;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic       sm;
        logic [7:0] a;
        logic [7:0] b;
        logic       e;
        logic       g;
        logic       l;
    } vec_t;

    vec_t v4[12];
    vec_t v8[8];

    comparator #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (iv4),
        .signed_mode (sm4),
        .a           (a4),
        .b           (b4),
        .out_valid   (ov4),
        .eq          (eq4),
        .gr          (gr4),
        .less        (lt4)
    );

    comparator #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (iv8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .out_valid   (ov8),
        .eq          (eq8),
        .gr          (gr8),
        .less        (lt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp_v);
        total_cnt++;
        if (act === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b", name, act, exp_v);
        end
    endtask

    task automatic check4(input string tag, input logic v, input logic e, input logic g,
                          input logic l);
        check({tag, ".out_valid"}, ov4, v);
        check({tag, ".eq"}, eq4, e);
        check({tag, ".gr"}, gr4, g);
        check({tag, ".less"}, lt4, l);
    endtask

    task automatic check8(input string tag, input logic v, input logic e, input logic g,
                          input logic l);
        check({tag, ".out_valid"}, ov8, v);
        check({tag, ".eq"}, eq8, e);
        check({tag, ".gr"}, gr8, g);
        check({tag, ".less"}, lt8, l);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        //            sm    a      b      eq    gr    less
        v4[0]  = '{1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b0};
        v4[1]  = '{1'b0, 8'hA, 8'hD, 1'b0, 1'b0, 1'b1};  // 10 < 13
        v4[2]  = '{1'b0, 8'h7, 8'h8, 1'b0, 1'b0, 1'b1};  // 7 < 8
        v4[3]  = '{1'b1, 8'h7, 8'h8, 1'b0, 1'b1, 1'b0};  // 7 > -8
        v4[4]  = '{1'b1, 8'hA, 8'hD, 1'b0, 1'b0, 1'b1};  // -6 < -3
        v4[5]  = '{1'b1, 8'hD, 8'hA, 1'b0, 1'b1, 1'b0};  // -3 > -6
        v4[6]  = '{1'b1, 8'h8, 8'h7, 1'b0, 1'b0, 1'b1};  // -8 < 7
        v4[7]  = '{1'b1, 8'h8, 8'hF, 1'b0, 1'b0, 1'b1};  // -8 < -1
        v4[8]  = '{1'b1, 8'hF, 8'hF, 1'b1, 1'b0, 1'b0};
        v4[9]  = '{1'b1, 8'h0, 8'hF, 1'b0, 1'b1, 1'b0};  // 0 > -1
        v4[10] = '{1'b0, 8'hF, 8'h0, 1'b0, 1'b1, 1'b0};  // 15 > 0
        v4[11] = '{1'b1, 8'h5, 8'h5, 1'b1, 1'b0, 1'b0};

        v8[0]  = '{1'b0, 8'h12, 8'h21, 1'b0, 1'b0, 1'b1};  // upper nibble decides
        v8[1]  = '{1'b0, 8'h35, 8'h34, 1'b0, 1'b1, 1'b0};  // only lower nibble differs
        v8[2]  = '{1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1};  // -128 < 127
        v8[3]  = '{1'b0, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b1};  // 127 < 128
        v8[4]  = '{1'b1, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1};  // -16 < 15
        v8[5]  = '{1'b1, 8'h9A, 8'h9A, 1'b1, 1'b0, 1'b0};
        v8[6]  = '{1'b1, 8'hFE, 8'hFD, 1'b0, 1'b1, 1'b0};  // -2 > -3
        v8[7]  = '{1'b1, 8'h12, 8'h21, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        iv4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        iv8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;

        // Reset state, with a valid sample presented while rst is held.
        iv4 = 1'b1; a4 = 4'hF;
        repeat (2) @(negedge clk);
        check4("reset4", 1'b0, 1'b0, 1'b0, 1'b0);
        check8("reset8", 1'b0, 1'b0, 1'b0, 1'b0);
        iv4 = 1'b0; a4 = '0;
        rst = 1'b0;

        // 4-bit table, back-to-back valid samples.
        for (int i = 0; i < 12; i++) begin
            iv4 = 1'b1;
            sm4 = v4[i].sm;
            a4  = v4[i].a[3:0];
            b4  = v4[i].b[3:0];
            @(negedge clk);
            check4($sformatf("v4[%0d]", i), 1'b1, v4[i].e, v4[i].g, v4[i].l);
        end
        iv4 = 1'b0;

        // 8-bit table.
        for (int i = 0; i < 8; i++) begin
            iv8 = 1'b1;
            sm8 = v8[i].sm;
            a8  = v8[i].a;
            b8  = v8[i].b;
            @(negedge clk);
            check8($sformatf("v8[%0d]", i), 1'b1, v8[i].e, v8[i].g, v8[i].l);
        end
        iv8 = 1'b0;
        @(negedge clk);
        check("v8_idle.out_valid", ov8, 1'b0);

        // Flags hold across idle cycles regardless of a/b.
        iv4 = 1'b1; sm4 = 1'b0; a4 = 4'h5; b4 = 4'h5;
        @(negedge clk);
        check4("hold_load", 1'b1, 1'b1, 1'b0, 1'b0);
        iv4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            sm4 = 1'($urandom);
            @(negedge clk);
            check4($sformatf("hold[%0d]", k), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        a4 = 'x; b4 = 'x; sm4 = 'x;
        @(negedge clk);
        check4("hold_x", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, well before the next rising edge.
        sm4 = 1'b0; a4 = 4'hF; b4 = 4'h0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check4("async_rst4", 1'b0, 1'b0, 1'b0, 1'b0);
        check8("async_rst8", 1'b0, 1'b0, 1'b0, 1'b0);
        iv4 = 1'b1;
        @(posedge clk);
        #1;
        check4("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);

        // First edge after release samples again.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check4("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);
        iv4 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/comparator.md
Name: comparator

Overview:
- Registered magnitude comparator for two WIDTH-bit operands.
- Asserts exactly one of eq / gr / less for each accepted sample.
- Supports unsigned and two's-complement signed comparison, selected per sample.
- Used as a leaf compare stage in datapaths that need a clean, registered, one-hot relation flag set with a valid qualifier.

Parameters:
- WIDTH, 4, operand width in bits; must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  qualifies a, b and signed_mode this cycle.
- signed_mode  input  1  1 = compare as two's complement; 0 = unsigned.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result flags correspond to a newly accepted sample.
- eq  output  1  registered A == B.
- gr  output  1  registered A > B.
- less  output  1  registered A < B.

Behaviour:
- Reset:
  - rst asserted clears eq, gr, less and out_valid to 0 immediately, independent of clk.
  - Outputs stay 0 while rst is high.
  - Sampling resumes on the first rising clk edge after rst deasserts.
- Latency is one cycle. On a rising edge with in_valid=1:
  - the relation of a and b under signed_mode is registered into eq / gr / less;
  - out_valid is set to 1.
- Rising edge with in_valid=0:
  - out_valid goes to 0;
  - eq / gr / less hold their last value.
- One-hot rule: after the first accepted sample following reset, exactly one of eq, gr, less is 1 at all times.
- Equality:
  - bitwise identity of a and b;
  - unaffected by signed_mode.
- Unsigned mode: plain magnitude compare of all WIDTH bits.
- Signed mode:
  - MSB is the sign bit;
  - if the sign bits differ, the operand with MSB=0 is greater;
  - otherwise the lower bits are compared as unsigned.
  - Example: most negative value (1000 for WIDTH=4) is less than every other value.
- Compare structure:
  - operands are split into WIDTH/4 nibble slices;
  - each slice yields slice_eq / slice_gt;
  - the slices are combined MSB-slice-first: the first non-equal slice from the top decides gr vs less; all slices equal means eq.
  - The signed correction is applied only to the top slice's MSB.
- No combinational path from inputs to outputs; all outputs come from flops.
- Back-to-back valid samples are accepted every cycle with no stalls and no backpressure.
- X or undriven inputs with in_valid=0 must not disturb the held flags.

Decomposition:
- Shared package comparator_pkg holds:
  - localparam SLICE_W = 4;
  - a typedef for the 3-bit relation code (REL_EQ, REL_GT, REL_LT);
  - a function converting the relation code to the one-hot eq/gr/less triple.
- One sub-module, comparator_slice:
  - compares one 4-bit nibble pair;
  - outputs slice_eq and slice_gt;
  - has an input flag telling it to treat its MSB as a sign bit (driven only for the top slice when signed_mode=1).
- The top level generates WIDTH/4 slices, combines them in a priority cascade, and registers the result.

Test Plan:
- Reset then a=0000, b=0000, unsigned, in_valid=1 -> one cycle later eq=1, gr=0, less=0, out_valid=1.
- a=1010, b=1101, unsigned -> eq=0, gr=0, less=1 (10 < 13).
- a=0111, b=1000:
  - unsigned -> less=1;
  - signed -> gr=1 (7 > -8).
- a=1010, b=1101, signed -> less=1 (-6 < -3); then a=1101, b=1010, signed -> gr=1.
- Valid sample (eq=1), then in_valid=0 for 3 cycles with random a/b -> out_valid=0 and eq stays 1. Assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge.
- WIDTH=8: a=0x12, b=0x21 (upper nibbles differ) and a=0x35, b=0x34 (only lower nibble differs) -> less=1 then gr=1, each one cycle after its valid sample.
